// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: sync, active-area coordinates, look-ahead coordinates, line/frame strobes.
// Outputs register the pre-increment position 1 clk after a ce_i tick; with ce_i low, levels hold and strobes stay low.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit H_POL     = 1'b0,
    parameter bit V_POL     = 1'b0,
    parameter int LOOKAHEAD = 2,
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW       = $clog2(H_TOTAL),
    localparam int YW       = $clog2(V_TOTAL)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ce_i,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          de_o,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          de_early_o,
    output logic [XW-1:0] x_early_o,
    output logic [YW-1:0] y_early_o,
    output logic          line_start_o,
    output logic          frame_start_o,
    output logic          vblank_o
);

    if (LOOKAHEAD < 0 || LOOKAHEAD >= H_TOTAL) begin : g_bad_lookahead
        $error("vga_timing_gen: LOOKAHEAD must lie in 0..H_TOTAL-1");
    end

    // One extra bit so porch/sync boundaries equal to 2**XW still compare correctly.
    localparam logic [XW:0]   H_ACT_C = (XW+1)'(H_ACTIVE);
    localparam logic [XW:0]   H_SS_C  = (XW+1)'(H_ACTIVE + H_FP);
    localparam logic [XW:0]   H_SE_C  = (XW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW:0]   V_ACT_C = (YW+1)'(V_ACTIVE);
    localparam logic [YW:0]   V_SS_C  = (YW+1)'(V_ACTIVE + V_FP);
    localparam logic [YW:0]   V_SE_C  = (YW+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [XW-1:0] H_LAST  = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_LAST  = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] H_LA    = XW'(LOOKAHEAD);

    logic [XW-1:0] h_q, h_d, he_q, he_d;
    logic [YW-1:0] v_q, v_d, ve_q, ve_d;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (ce_i) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_comb begin
        he_d = he_q;
        ve_d = ve_q;
        if (ce_i) begin
            if (he_q == H_LAST) begin
                he_d = '0;
                ve_d = (ve_q == V_LAST) ? '0 : ve_q + 1'b1;
            end else begin
                he_d = he_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_q  <= '0;
            v_q  <= '0;
            he_q <= H_LA;
            ve_q <= '0;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            he_q <= he_d;
            ve_q <= ve_d;
        end
    end

    logic de_m, hs_m, vs_m, vb_m, de_e;

    assign de_m = ({1'b0, h_q} < H_ACT_C) && ({1'b0, v_q} < V_ACT_C);
    assign hs_m = ({1'b0, h_q} >= H_SS_C) && ({1'b0, h_q} < H_SE_C);
    // v only moves on a line wrap, so vsync edges land on line-start ticks.
    assign vs_m = ({1'b0, v_q} >= V_SS_C) && ({1'b0, v_q} < V_SE_C);
    assign vb_m = ({1'b0, v_q} >= V_ACT_C);
    assign de_e = ({1'b0, he_q} < H_ACT_C) && ({1'b0, ve_q} < V_ACT_C);

    logic          hsync_q, vsync_q, de_q, de_early_q;
    logic          line_start_q, frame_start_q, vblank_q;
    logic [XW-1:0] x_q, x_early_q;
    logic [YW-1:0] y_q, y_early_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            de_early_q    <= 1'b0;
            x_early_q     <= '0;
            y_early_q     <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            vblank_q      <= 1'b0;
        end else begin
            line_start_q  <= ce_i && (h_q == '0);
            frame_start_q <= ce_i && (h_q == '0) && (v_q == '0);
            if (ce_i) begin
                hsync_q    <= hs_m ? H_POL : ~H_POL;
                vsync_q    <= vs_m ? V_POL : ~V_POL;
                de_q       <= de_m;
                x_q        <= de_m ? h_q : '0;
                y_q        <= de_m ? v_q : '0;
                de_early_q <= de_e;
                x_early_q  <= de_e ? he_q : '0;
                y_early_q  <= de_e ? ve_q : '0;
                vblank_q   <= vb_m;
            end
        end
    end

    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign de_o          = de_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign de_early_o    = de_early_q;
    assign x_early_o     = x_early_q;
    assign y_early_o     = y_early_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;
    assign vblank_o      = vblank_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a small 15x8 raster: one instance with look-ahead 3 / active-low syncs, one with look-ahead 0 / active-high syncs.
module tb_vga_timing_gen;

    localparam int HT = 15, VT = 8, FR = HT * VT;
    localparam int HA = 8, HS0 = 10, HS1 = 13;
    localparam int VA = 4, VS0 = 5, VS1 = 7;
    localparam int LA = 3;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [3:0] x;
        logic [2:0] y;
        logic       dee;
        logic [3:0] xe;
        logic [2:0] ye;
        logic       ls;
        logic       fs;
        logic       vb;
    } exp_t;

    typedef struct {
        exp_t a;
        exp_t b;
        int   tick;
    } sb_t;

    typedef struct {
        int   n;
        exp_t e;
    } cp_t;

    logic clk = 1'b0;
    logic rst_i, ce_i;
    always #5 clk = ~clk;

    logic       a_hs, a_vs, a_de, a_dee, a_ls, a_fs, a_vb;
    logic [3:0] a_x, a_xe;
    logic [2:0] a_y, a_ye;
    logic       b_hs, b_vs, b_de, b_dee, b_ls, b_fs, b_vb;
    logic [3:0] b_x, b_xe;
    logic [2:0] b_y, b_ye;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(VA), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0), .LOOKAHEAD(LA)
    ) u_a (
        .clk_i(clk), .rst_i(rst_i), .ce_i(ce_i),
        .hsync_o(a_hs), .vsync_o(a_vs), .de_o(a_de), .x_o(a_x), .y_o(a_y),
        .de_early_o(a_dee), .x_early_o(a_xe), .y_early_o(a_ye),
        .line_start_o(a_ls), .frame_start_o(a_fs), .vblank_o(a_vb)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(VA), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .LOOKAHEAD(0)
    ) u_b (
        .clk_i(clk), .rst_i(rst_i), .ce_i(ce_i),
        .hsync_o(b_hs), .vsync_o(b_vs), .de_o(b_de), .x_o(b_x), .y_o(b_y),
        .de_early_o(b_dee), .x_early_o(b_xe), .y_early_o(b_ye),
        .line_start_o(b_ls), .frame_start_o(b_fs), .vblank_o(b_vb)
    );

    int   n_chk = 0, n_fail = 0, cyc = 0, pos = 0;
    int   de_n, hs_lo, vs_lo, ls_n;
    int   fs_cyc[$];
    exp_t last_a, last_b, act_a, act_b;
    sb_t  sb_q[$];
    cp_t  cps[$];

    function automatic exp_t mk(input logic hs, input logic vs, input logic de,
                                input int x, input int y, input logic dee,
                                input int xe, input int ye, input logic ls,
                                input logic fs, input logic vb);
        exp_t e;
        e.hs = hs; e.vs = vs; e.de = de; e.x = 4'(x); e.y = 3'(y);
        e.dee = dee; e.xe = 4'(xe); e.ye = 3'(ye);
        e.ls = ls; e.fs = fs; e.vb = vb;
        return e;
    endfunction

    function automatic exp_t rst_val(input logic hp, input logic vp);
        exp_t e;
        e = '0;
        e.hs = ~hp;
        e.vs = ~vp;
        return e;
    endfunction

    // Expected outputs after the tick that presents raster index t.
    function automatic exp_t model(input int t, input int la, input logic hp, input logic vp);
        exp_t e;
        int h, v, he, ve;
        h  = (t % FR) % HT;
        v  = (t % FR) / HT;
        he = ((t + la) % FR) % HT;
        ve = ((t + la) % FR) / HT;
        e.de  = (h < HA) && (v < VA);
        e.x   = e.de ? 4'(h) : 4'd0;
        e.y   = e.de ? 3'(v) : 3'd0;
        e.dee = (he < HA) && (ve < VA);
        e.xe  = e.dee ? 4'(he) : 4'd0;
        e.ye  = e.dee ? 3'(ve) : 3'd0;
        e.hs  = (h >= HS0 && h < HS1) ? hp : ~hp;
        e.vs  = (v >= VS0 && v < VS1) ? vp : ~vp;
        e.ls  = (h == 0);
        e.fs  = ((t % FR) == 0);
        e.vb  = (v >= VA);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic clear_meas();
        de_n = 0; hs_lo = 0; vs_lo = 0; ls_n = 0;
        fs_cyc.delete();
    endtask

    task automatic step(input logic r, input logic c);
        sb_t e;
        rst_i = r;
        ce_i  = c;
        if (r) begin
            e.a = rst_val(1'b0, 1'b0);
            e.b = rst_val(1'b1, 1'b1);
            e.tick = 0;
            pos = 0;
        end else if (c) begin
            e.a = model(pos, LA, 1'b0, 1'b0);
            e.b = model(pos, 0, 1'b1, 1'b1);
            pos++;
            e.tick = pos;
        end else begin
            e.a = last_a; e.a.ls = 1'b0; e.a.fs = 1'b0;
            e.b = last_b; e.b.ls = 1'b0; e.b.fs = 1'b0;
            e.tick = 0;
        end
        last_a = e.a;
        last_b = e.b;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        act_a = {a_hs, a_vs, a_de, a_x, a_y, a_dee, a_xe, a_ye, a_ls, a_fs, a_vb};
        act_b = {b_hs, b_vs, b_de, b_x, b_y, b_dee, b_xe, b_ye, b_ls, b_fs, b_vb};
        e = sb_q.pop_front();
        chk("dut_a_outputs", act_a, e.a);
        chk("dut_b_outputs", act_b, e.b);
        if (e.tick != 0)
            foreach (cps[i])
                if (cps[i].n == e.tick)
                    chk($sformatf("checkpoint_tick%0d", e.tick), act_a, cps[i].e);
        if (a_de) de_n++;
        if (!a_hs) hs_lo++;
        if (!a_vs) vs_lo++;
        if (a_ls) ls_n++;
        if (a_fs) fs_cyc.push_back(cyc);
    endtask

    task automatic chk_frames(input string nm, input int want_n, input int gap);
        chk({nm, "_frame_count"}, fs_cyc.size(), want_n);
        for (int i = 1; i < fs_cyc.size(); i++)
            chk({nm, "_frame_length"}, fs_cyc[i] - fs_cyc[i-1], gap);
    endtask

    initial begin
        // Hand-derived checkpoints for the look-ahead-3 instance, keyed by tick number since reset.
        cps.push_back('{1,   mk(1,1,1,0,0, 1,3,0, 1,1,0)});
        cps.push_back('{8,   mk(1,1,1,7,0, 0,0,0, 0,0,0)});
        cps.push_back('{11,  mk(0,1,0,0,0, 0,0,0, 0,0,0)});
        cps.push_back('{13,  mk(0,1,0,0,0, 1,0,1, 0,0,0)});
        cps.push_back('{14,  mk(1,1,0,0,0, 1,1,1, 0,0,0)});
        cps.push_back('{16,  mk(1,1,1,0,1, 1,3,1, 1,0,0)});
        cps.push_back('{61,  mk(1,1,0,0,0, 0,0,0, 1,0,1)});
        cps.push_back('{75,  mk(1,1,0,0,0, 0,0,0, 0,0,1)});
        cps.push_back('{76,  mk(1,0,0,0,0, 0,0,0, 1,0,1)});
        cps.push_back('{105, mk(1,0,0,0,0, 0,0,0, 0,0,1)});
        cps.push_back('{106, mk(1,1,0,0,0, 0,0,0, 1,0,1)});
        cps.push_back('{118, mk(0,1,0,0,0, 1,0,0, 0,0,1)});
        cps.push_back('{121, mk(1,1,1,0,0, 1,3,0, 1,1,0)});
        cps.push_back('{125, mk(1,1,1,4,0, 1,7,0, 0,0,0)});

        rst_i = 1'b1;
        ce_i  = 1'b0;
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);

        // Two full-rate frames.
        clear_meas();
        for (int i = 0; i < 2 * FR; i++) step(1'b0, 1'b1);
        chk_frames("full_rate", 2, FR);
        chk("line_starts", ls_n, 2 * VT);
        chk("de_cycles", de_n, 2 * HA * VA);
        chk("hsync_low_cycles", hs_lo, 2 * VT * (HS1 - HS0));
        chk("vsync_low_cycles", vs_lo, 2 * HT * (VS1 - VS0));

        // Half-rate ticks: frames double in length, strobes stay single-cycle.
        clear_meas();
        for (int i = 0; i < 500; i++) step(1'b0, (i % 2) == 0);
        chk_frames("half_rate", 3, 2 * FR);
        chk("half_rate_line_starts", ls_n, 17);

        // Reset in the middle of line 3, column 7.
        for (int k = 0; k < FR && (pos % FR) != 3 * HT + 7; k++) step(1'b0, 1'b1);
        chk("mid_frame_position", pos % FR, 3 * HT + 7);
        step(1'b1, 1'b1);
        chk("mid_reset_a", act_a, mk(1,1,0,0,0, 0,0,0, 0,0,0));
        chk("mid_reset_b", act_b, mk(0,0,0,0,0, 0,0,0, 0,0,0));
        clear_meas();
        step(1'b0, 1'b1);
        chk("restart_origin", act_a, mk(1,1,1,0,0, 1,3,0, 1,1,0));
        for (int i = 0; i < FR + 10; i++) step(1'b0, 1'b1);
        chk_frames("after_reset", 2, FR);

        // Irregular tick pattern.
        for (int i = 0; i < 300; i++) step(1'b0, 1'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
